// File: rtl/tcdm_model_pkg.sv
// Shared types, constants and helpers for the multi-bank TCDM bench model.
// Typedefs describe the default 32-bit / 4-byte / 2-bit-ID configuration.
package tcdm_model_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  be_t;
    typedef logic [1:0]  id_t;

    localparam int INIT_KEEP  = 0;
    localparam int INIT_CLEAR = 1;
    localparam int INIT_INDEX = 2;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/tcdm_rr_arbiter.sv
// Round-robin arbiter for one bank: one-hot grant to the first requester at or
// after the pointer; the pointer moves past the winner only when someone wins.
module tcdm_rr_arbiter
    import tcdm_model_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_gnt
);

    localparam int PW = clog2_min1(N);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next_ptr;
    logic          w_any;
    int            w_idx;

    always_comb begin
        o_gnt      = '0;
        w_any      = 1'b0;
        w_next_ptr = r_ptr;
        w_idx      = 0;
        for (int i = 0; i < N; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= N) w_idx = w_idx - N;
            if (!w_any && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_any        = 1'b1;
                w_next_ptr   = (w_idx == N - 1) ? '0 : PW'(w_idx + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule

// File: rtl/tcdm_multibank_model.sv
// Multi-banked, word-interleaved TCDM model: per-bank RR arbitration, LFSR stall
// injection, byte-enable writes and a LATENCY-deep read response pipe per port.
module tcdm_multibank_model
    import tcdm_model_pkg::*;
#(
    parameter int                  N_PORTS        = 4,
    parameter int                  N_BANKS        = 8,
    parameter int                  DATA_WIDTH     = 32,
    parameter int                  ADDR_WIDTH     = 32,
    parameter int                  WORDS_PER_BANK = 1024,
    parameter int                  ID_WIDTH       = 2,
    parameter int                  LATENCY        = 1,
    parameter int                  STALL_P1024    = 0,
    parameter logic [15:0]         LFSR_SEED      = 16'hACE1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                  INIT_MODE      = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  stall_en_i,
    input  logic [N_PORTS-1:0]                    req_i,
    output logic [N_PORTS-1:0]                    gnt_o,
    input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]    add_i,
    input  logic [N_PORTS-1:0]                    wen_i,
    input  logic [N_PORTS-1:0][DATA_WIDTH/8-1:0]  be_i,
    input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]    data_i,
    input  logic [N_PORTS-1:0][ID_WIDTH-1:0]      id_i,
    output logic [N_PORTS-1:0][DATA_WIDTH-1:0]    r_data_o,
    output logic [N_PORTS-1:0]                    r_valid_o,
    output logic [N_PORTS-1:0]                    r_err_o,
    output logic [N_PORTS-1:0][ID_WIDTH-1:0]      r_id_o
);

    localparam int BE_W      = DATA_WIDTH / 8;
    localparam int OFF_BITS  = $clog2(BE_W);
    localparam int BANK_BITS = clog2_min1(N_BANKS);
    localparam int ROW_BITS  = clog2_min1(WORDS_PER_BANK);
    localparam logic [ADDR_WIDTH-1:0] TOTAL_W = ADDR_WIDTH'(N_BANKS * WORDS_PER_BANK);

    logic [ADDR_WIDTH-1:0] w_off  [N_PORTS];
    logic [ADDR_WIDTH-1:0] w_word [N_PORTS];
    logic [BANK_BITS-1:0]  w_bank [N_PORTS];
    logic [ROW_BITS-1:0]   w_row  [N_PORTS];
    logic [DATA_WIDTH-1:0] w_rdata[N_PORTS];
    logic [N_PORTS-1:0]    w_oor, w_stall, w_win, w_gnt, w_issue;

    logic [N_BANKS-1:0][N_PORTS-1:0] w_bank_req;
    logic [N_BANKS-1:0][N_PORTS-1:0] w_bank_gnt;

    logic [15:0]           r_lfsr [N_PORTS];
    logic [DATA_WIDTH-1:0] r_mem  [N_BANKS][WORDS_PER_BANK];
    logic [LATENCY-1:0]    r_pv   [N_PORTS];
    logic [LATENCY-1:0]    r_pe   [N_PORTS];
    logic [ID_WIDTH-1:0]   r_pid  [N_PORTS][LATENCY];
    logic [DATA_WIDTH-1:0] r_pd   [N_PORTS][LATENCY];

    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            w_off[p]   = add_i[p] - BASE_ADDR;
            w_word[p]  = w_off[p] >> OFF_BITS;
            w_oor[p]   = (add_i[p] < BASE_ADDR) || (w_word[p] >= TOTAL_W);
            w_bank[p]  = w_word[p][BANK_BITS-1:0];
            w_row[p]   = w_word[p][BANK_BITS +: ROW_BITS];
            w_stall[p] = stall_en_i & ({1'b0, r_lfsr[p][9:0]} < 11'(STALL_P1024));
            w_rdata[p] = w_oor[p] ? '0 : r_mem[w_bank[p]][w_row[p]];
        end
    end

    // Out-of-range requests never enter bank arbitration.
    always_comb begin
        w_bank_req = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            for (int p = 0; p < N_PORTS; p++) begin
                w_bank_req[b][p] = req_i[p] & ~w_stall[p] & ~w_oor[p] &
                                   (w_bank[p] == BANK_BITS'(b));
            end
        end
    end

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        tcdm_rr_arbiter #(.N(N_PORTS)) u_arb (
            .clk   (clk),
            .rst   (rst),
            .i_req (w_bank_req[b]),
            .o_gnt (w_bank_gnt[b])
        );
    end

    always_comb begin
        w_win = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            w_win = w_win | w_bank_gnt[b];
        end
        for (int p = 0; p < N_PORTS; p++) begin
            w_gnt[p]   = ~rst & req_i[p] & ~w_stall[p] & (w_oor[p] | w_win[p]);
            w_issue[p] = w_gnt[p] & (~wen_i[p] | w_oor[p]);
        end
    end

    assign gnt_o = w_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < N_BANKS; b++) begin
                for (int r = 0; r < WORDS_PER_BANK; r++) begin
                    if (INIT_MODE == INIT_CLEAR) r_mem[b][r] <= '0;
                    else if (INIT_MODE == INIT_INDEX) r_mem[b][r] <= DATA_WIDTH'(r * N_BANKS + b);
                end
            end
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                if (w_gnt[p] && wen_i[p] && !w_oor[p]) begin
                    for (int i = 0; i < BE_W; i++) begin
                        if (be_i[p][i]) r_mem[w_bank[p]][w_row[p]][8*i +: 8] <= data_i[p][8*i +: 8];
                    end
                end
            end
        end
    end

    // Each stage reloads data/id only with a valid entry, so the last stage holds its value between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < N_PORTS; p++) begin
                r_lfsr[p] <= LFSR_SEED ^ 16'(p + 1);
                r_pv[p]   <= '0;
                r_pe[p]   <= '0;
                for (int s = 0; s < LATENCY; s++) begin
                    r_pid[p][s] <= '0;
                    r_pd[p][s]  <= '0;
                end
            end
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                r_lfsr[p]  <= lfsr_step(r_lfsr[p]);
                r_pv[p][0] <= w_issue[p];
                if (w_issue[p]) begin
                    r_pe[p][0]  <= w_oor[p];
                    r_pid[p][0] <= id_i[p];
                    r_pd[p][0]  <= w_rdata[p];
                end
                for (int s = 1; s < LATENCY; s++) begin
                    r_pv[p][s] <= r_pv[p][s-1];
                    if (r_pv[p][s-1]) begin
                        r_pe[p][s]  <= r_pe[p][s-1];
                        r_pid[p][s] <= r_pid[p][s-1];
                        r_pd[p][s]  <= r_pd[p][s-1];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            r_valid_o[p] = r_pv[p][LATENCY-1] & ~rst;
            r_err_o[p]   = r_pv[p][LATENCY-1] & r_pe[p][LATENCY-1] & ~rst;
            r_data_o[p]  = r_pd[p][LATENCY-1];
            r_id_o[p]    = r_pid[p][LATENCY-1];
        end
    end

endmodule

// File: tb/tb_tcdm_multibank_model.sv
// Directed bench for tcdm_multibank_model: latency, byte enables, range errors,
// reset flush, round-robin rotation and the deterministic stall sequence.
module tb_tcdm_multibank_model;

    localparam int          NP   = 4;
    localparam int          LAT  = 3;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [15:0] SEED = 16'hACE1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              stall_en_i = 1'b0;
    logic [NP-1:0]     req_i = '0;
    logic [NP-1:0]     gnt_o;
    logic [NP-1:0][31:0] add_i = '0;
    logic [NP-1:0]     wen_i = '0;
    logic [NP-1:0][3:0]  be_i = '0;
    logic [NP-1:0][31:0] data_i = '0;
    logic [NP-1:0][1:0]  id_i = '0;
    logic [NP-1:0][31:0] r_data_o;
    logic [NP-1:0]     r_valid_o;
    logic [NP-1:0]     r_err_o;
    logic [NP-1:0][1:0]  r_id_o;

    int n_checks = 0;
    int n_errors = 0;

    tcdm_multibank_model #(
        .N_PORTS(NP), .N_BANKS(8), .DATA_WIDTH(32), .ADDR_WIDTH(32),
        .WORDS_PER_BANK(64), .ID_WIDTH(2), .LATENCY(LAT), .STALL_P1024(512),
        .LFSR_SEED(SEED), .BASE_ADDR(BASE), .INIT_MODE(2)
    ) dut (
        .clk(clk), .rst(rst), .stall_en_i(stall_en_i), .req_i(req_i), .gnt_o(gnt_o),
        .add_i(add_i), .wen_i(wen_i), .be_i(be_i), .data_i(data_i), .id_i(id_i),
        .r_data_o(r_data_o), .r_valid_o(r_valid_o), .r_err_o(r_err_o), .r_id_o(r_id_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
    endtask

    // Holds the request until granted, then drops it; returns at the drive point of the cycle after the grant.
    task automatic issue(input int p, input logic [31:0] a, input logic w, input logic [3:0] be,
                         input logic [31:0] d, input logic [1:0] id, output int waits);
        req_i[p] = 1'b1; add_i[p] = a; wen_i[p] = w; be_i[p] = be; data_i[p] = d; id_i[p] = id;
        waits = 0;
        while (1) begin
            @(negedge clk);
            if (gnt_o[p]) break;
            if (waits >= 50) begin
                check("gnt_timeout", 64'd0, 64'd1);
                break;
            end
            waits++;
            cycle();
        end
        cycle();
        req_i[p] = 1'b0;
    endtask

    task automatic wait_resp(input int p, output logic [31:0] d, output logic err,
                             output logic [1:0] rid, output int lat);
        logic found;
        found = 1'b0; d = '0; err = 1'b0; rid = '0; lat = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (r_valid_o[p]) begin
                found = 1'b1; lat = c; d = r_data_o[p]; err = r_err_o[p]; rid = r_id_o[p];
            end
            cycle();
            if (found) break;
        end
        if (!found) check("resp_timeout", 64'd0, 64'd1);
    endtask

    task automatic read_word(input int p, input logic [31:0] a, input logic [1:0] id,
                             output logic [31:0] d, output logic err, output logic [1:0] rid, output int lat);
        int waits;
        issue(p, a, 1'b0, 4'h0, 32'h0, id, waits);
        wait_resp(p, d, err, rid, lat);
    endtask

    task automatic write_word(input int p, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        int waits;
        issue(p, a, 1'b1, be, d, 2'd0, waits);
    endtask

    task automatic stall_run(input string tag);
        logic [15:0] m;
        int grants, mism;
        logic exp_g;
        do_reset();
        stall_en_i = 1'b1;
        req_i[0] = 1'b1; add_i[0] = BASE + 32'h40; wen_i[0] = 1'b0;
        m = SEED ^ 16'h0001;
        grants = 0; mism = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            exp_g = (m[9:0] >= 10'd512);
            if (gnt_o[0] !== exp_g) mism++;
            if (gnt_o[0]) grants++;
            cycle();
            m = m[0] ? ((m >> 1) ^ 16'hB400) : (m >> 1);
        end
        req_i[0] = 1'b0;
        stall_en_i = 1'b0;
        repeat (6) cycle();
        check({tag, "_trace"}, 64'(mism), 64'd0);
        check({tag, "_ratio"}, 64'((grants >= 4500) && (grants <= 5500)), 64'd1);
    endtask

    initial begin
        logic [31:0] d;
        logic        err;
        logic [1:0]  rid;
        int          lat, waits, nv;
        int          cnt [NP];
        logic [31:0] init_idx [3];

        // reset state, with a request pending during reset
        req_i[0] = 1'b1; add_i[0] = BASE;
        repeat (2) begin
            @(negedge clk);
            check("rst_gnt", 64'(gnt_o), 64'd0);
            cycle();
        end
        req_i[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 64'(r_valid_o), 64'd0);
        check("rst_rdata", 64'(r_data_o == '0), 64'd1);
        cycle();

        // INIT_MODE=2 contents: word k holds k
        init_idx[0] = 0; init_idx[1] = 5; init_idx[2] = 13;
        for (int i = 0; i < 3; i++) begin
            read_word(i % NP, BASE + init_idx[i] * 4, 2'(i), d, err, rid, lat);
            check("init_word", 64'(d), 64'(init_idx[i]));
        end

        // single write then read, latency and id echo
        write_word(0, BASE + 32'h10, 4'hF, 32'hDEADBEEF);
        read_word(0, BASE + 32'h10, 2'd2, d, err, rid, lat);
        check("rd_lat", 64'(lat), 64'(LAT));
        check("rd_data", 64'(d), 64'hDEADBEEF);
        check("rd_id", 64'(rid), 64'd2);
        check("rd_err", 64'(err), 64'd0);
        @(negedge clk);
        check("hold_valid", 64'(r_valid_o[0]), 64'd0);
        check("hold_data", 64'(r_data_o[0]), 64'hDEADBEEF);
        cycle();

        // byte enables
        write_word(1, BASE + 32'h24, 4'hF, 32'h11223344);
        write_word(1, BASE + 32'h24, 4'b0101, 32'hAABBCCDD);
        read_word(1, BASE + 32'h24, 2'd1, d, err, rid, lat);
        check("be_data", 64'(d), 64'h11BB33DD);
        write_word(1, BASE + 32'h24, 4'b0000, 32'hFFFFFFFF);
        read_word(1, BASE + 32'h24, 2'd1, d, err, rid, lat);
        check("be_zero", 64'(d), 64'h11BB33DD);

        // out of range, above top and below base
        issue(2, BASE + 32'h800, 1'b0, 4'h0, 32'h0, 2'd3, waits);
        wait_resp(2, d, err, rid, lat);
        check("oor_gnt_wait", 64'(waits), 64'd0);
        check("oor_lat", 64'(lat), 64'(LAT));
        check("oor_err", 64'(err), 64'd1);
        check("oor_data", 64'(d), 64'd0);
        check("oor_id", 64'(rid), 64'd3);
        read_word(2, BASE - 32'h4, 2'd0, d, err, rid, lat);
        check("below_err", 64'(err), 64'd1);
        write_word(3, BASE, 4'hF, 32'h12345678);
        issue(3, BASE + 32'h800, 1'b1, 4'hF, 32'hCAFEF00D, 2'd1, waits);
        wait_resp(3, d, err, rid, lat);
        check("oor_wr_err", 64'(err), 64'd1);
        read_word(3, BASE, 2'd0, d, err, rid, lat);
        check("oor_wr_nochg", 64'(d), 64'h12345678);
        check("inrange_err", 64'(err), 64'd0);

        // different banks, same cycle: both granted
        req_i[0] = 1'b1; add_i[0] = BASE + 32'h0; wen_i[0] = 1'b0;
        req_i[1] = 1'b1; add_i[1] = BASE + 32'h4; wen_i[1] = 1'b0;
        @(negedge clk);
        check("two_banks", 64'(gnt_o), 64'b0011);
        cycle();
        req_i = '0;
        repeat (6) cycle();

        // reset with three reads in flight
        for (int i = 0; i < 3; i++) begin
            req_i[0] = 1'b1; add_i[0] = BASE + 32'(i * 4); wen_i[0] = 1'b0;
            @(negedge clk);
            check("burst_gnt", 64'(gnt_o[0]), 64'd1);
            cycle();
        end
        req_i[0] = 1'b0;
        rst = 1'b1;
        nv = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (r_valid_o[0]) nv++;
            cycle();
            if (c == 1) rst = 1'b0;
        end
        check("flush_valid", 64'(nv), 64'd0);
        read_word(0, BASE + 32'h10, 2'd0, d, err, rid, lat);
        check("reinit_word4", 64'(d), 64'd4);

        // bank-0 conflict among all ports: strict rotation
        do_reset();
        for (int p = 0; p < NP; p++) begin
            req_i[p] = 1'b1; add_i[p] = BASE + 32'(p * 32); wen_i[p] = 1'b0; cnt[p] = 0;
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("rr_rotate", 64'(gnt_o), 64'(4'b0001 << (c % 4)));
            for (int p = 0; p < NP; p++) if (gnt_o[p]) cnt[p]++;
            cycle();
        end
        req_i = '0;
        for (int p = 0; p < NP; p++) check("rr_share", 64'(cnt[p]), 64'd2);
        repeat (6) cycle();

        // deterministic stall injection, twice from the same seed
        stall_run("stall_a");
        stall_run("stall_b");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
